riscv_fetch: RTL and testbench

- Instruction fetch stage, directly upstream of riscv_decode.
- Holds the PC and issues word requests to instruction memory over a req/gnt/rvalid bus.
- Buffers returned instructions, each with its PC, in a small FIFO.
- Presents them to decode over a valid/ready handshake; supports redirect (branch/jump) with flush and discard of in-flight responses.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/riscv_fetch_fifo.sv | 75 +++++++
 rtl/riscv_fetch.sv | 136 +++++++++++++
 tb/tb_riscv_fetch.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CW'(DEPTH));
    count_o = count_q;
    head_o  = mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push_i && (!full_o || do_pop);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
module riscv_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]    pc_q, pc_d;
  logic [31:0]    rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  discard_q, discard_d;

  logic           gnt_acc;
  logic           rsp_live;
  logic [31:0]    redirect_target;

  logic           fifo_push;
  logic           fifo_pop;
  fetch_entry_t   fifo_push_data;
  fetch_entry_t   fifo_head;
  logic [FCW-1:0] fifo_count;
  logic           fifo_full;
  logic           fifo_empty;

  logic           unused_redirect_lsb;

  always_comb begin
    unused_redirect_lsb = ^redirect_pc_i[1:0];
    redirect_target     = {redirect_pc_i[31:2], 2'b00};
  end

  // Holding the request back until a slot is guaranteed means every response has room.
  always_comb begin
    imem_addr_o = pc_q;
    imem_req_o  = rst_n
               && ((int'(outstanding_q) + int'(discard_q)) < int'(MAX_OUTSTANDING))
               && ((int'(outstanding_q) + int'(fifo_count)) < int'(FIFO_DEPTH));
    gnt_acc     = imem_req_o && imem_gnt_i;
    rsp_live    = imem_rvalid_i && (discard_q == '0);
  end

  always_comb begin
    pc_d           = pc_q;
    rsp_pc_d       = rsp_pc_q;
    outstanding_d  = outstanding_q;
    discard_d      = discard_q;
    fifo_push      = 1'b0;
    fifo_push_data = '{pc: rsp_pc_q, instr: imem_rdata_i};

    if (redirect_i) begin
      pc_d          = redirect_target;
      rsp_pc_d      = redirect_target;
      outstanding_d = '0;
      // Everything in flight, plus a same-cycle grant, becomes discard; a
      // same-cycle response retires one of them whichever counter it hit.
      discard_d     = discard_q + outstanding_q + CW'(gnt_acc) - CW'(imem_rvalid_i);
    end else begin
      if (gnt_acc) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rvalid_i) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + 32'd4;
        end
      end
      outstanding_d = outstanding_q + CW'(gnt_acc) - CW'(rsp_live);
    end
  end

  always_comb begin
    instr_valid_o = !fifo_empty;
    instr_o       = fifo_head.instr;
    instr_pc_o    = fifo_head.pc;
    fifo_pop      = instr_valid_o && instr_ready_i;
  end

  riscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_i),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  a_inflight_bound : assert property (@(posedge clk) disable iff (!rst_n)
    (int'(outstanding_q) + int'(discard_q)) <= int'(MAX_OUTSTANDING));

  a_rsp_expected : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> ((outstanding_q != '0) || (discard_q != '0)));

  a_push_has_room : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_riscv_fetch.sv
module tb_riscv_fetch;
  import riscv_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned MAXO   = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  riscv_fetch #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    logic [31:0] pc;
    bit          disc;
  } infl_t;

  // Reference state: requests in flight (oldest first), buffered instructions, next fetch PC.
  infl_t        m_infl[$];
  fetch_entry_t m_fifo[$];
  logic [31:0]  m_pc = RST_PC;
  bit           m_known = 1'b0;
  bit           m_fresh = 1'b0;
  // Memory emulator: addresses it has accepted and not yet answered.
  logic [31:0]  mem_q[$];
  bit           rsp_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit exp_req();
    int live = 0;
    foreach (m_infl[i]) if (!m_infl[i].disc) live++;
    return (rst_n === 1'b1) && (m_infl.size() < MAXO) && ((live + m_fifo.size()) < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  always @(posedge clk) begin : model
    bit    acc;
    bit    pop;
    bit    have_rsp;
    infl_t front;
    if (rst_n !== 1'b1) begin
      m_infl.delete();
      m_fifo.delete();
      mem_q.delete();
      m_pc    = RST_PC;
      m_known = 1'b1;
      m_fresh = 1'b1;
    end else if (m_known) begin
      acc      = exp_req() && imem_gnt_i;
      pop      = (m_fifo.size() > 0) && instr_ready_i;
      have_rsp = 1'b0;
      front    = '{pc: 32'h0, disc: 1'b0};
      if (imem_rvalid_i) begin
        if (mem_q.size() > 0) void'(mem_q.pop_front());
        if (m_infl.size() > 0) begin
          front    = m_infl.pop_front();
          have_rsp = 1'b1;
        end
      end
      if (imem_req_o && imem_gnt_i) mem_q.push_back(imem_addr_o);
      if (redirect_i) begin
        m_fifo.delete();
        foreach (m_infl[i]) m_infl[i].disc = 1'b1;
        if (acc) m_infl.push_back('{pc: m_pc, disc: 1'b1});
        m_pc = {redirect_pc_i[31:2], 2'b00};
      end else begin
        if (pop) void'(m_fifo.pop_front());
        if (have_rsp && !front.disc) begin
          m_fifo.push_back('{pc: front.pc, instr: imem_rdata_i});
          m_fresh = 1'b0;
        end
        if (acc) begin
          m_infl.push_back('{pc: m_pc, disc: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("addr", imem_addr_o, m_pc);
      chk1("req", imem_req_o, exp_req());
      chk1("valid", instr_valid_o, m_fifo.size() > 0);
      if (m_fifo.size() > 0) begin
        chk("instr_pc", instr_pc_o, m_fifo[0].pc);
        chk("instr", instr_o, m_fifo[0].instr);
        chk("instr_vs_mem", instr_o, mem_word(instr_pc_o));
      end else if (m_fresh) begin
        chk("instr_rst", instr_o, 32'h0);
        chk("instr_pc_rst", instr_pc_o, 32'h0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    imem_rvalid_i = (rst_n === 1'b1) && rsp_en && (mem_q.size() > 0);
    imem_rdata_i  = imem_rvalid_i ? mem_word(mem_q[0]) : 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p0;
    logic [31:0] a;
    int          k;
    bit          found;

    rst_n         = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;
    rsp_en        = 1'b1;

    repeat (3) cyc();
    chk1("rst_req", imem_req_o, 1'b0);
    chk("rst_addr", imem_addr_o, RST_PC);
    chk1("rst_valid", instr_valid_o, 1'b0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_instr_pc", instr_pc_o, 32'h0);

    // Streaming: grant every cycle, response one cycle after grant.
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    rst_n         = 1'b1;
    #1;
    chk1("t1_req_first", imem_req_o, 1'b1);
    chk("t1_addr0", imem_addr_o, 32'h0);
    cyc();
    chk("t1_addr1", imem_addr_o, 32'h4);
    chk1("t1_valid_early", instr_valid_o, 1'b0);
    cyc();
    chk1("t1_valid", instr_valid_o, 1'b1);
    chk("t1_pc0", instr_pc_o, 32'h0);
    chk("t1_data0", instr_o, 32'h1357_6420);
    cyc();
    chk1("t1_valid1", instr_valid_o, 1'b1);
    chk("t1_pc1", instr_pc_o, 32'h4);
    repeat (16) cyc();

    // Decode stall fills the buffer; order must survive release.
    instr_ready_i = 1'b0;
    repeat (10) cyc();
    chk1("t2_full_valid", instr_valid_o, 1'b1);
    chk1("t2_req_blocked", imem_req_o, 1'b0);
    p0 = instr_pc_o;
    instr_ready_i = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid_o) begin
        chk("t2_order", instr_pc_o, p0 + 32'(4 * k));
        k++;
      end
      cyc();
    end
    chk1("t2_progress", k >= 4, 1'b1);

    // Redirect with two requests in flight.
    rsp_en = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_infl.size() == 2 && m_fifo.size() == 0) found = 1'b1;
      else cyc();
    end
    chk1("t3_two_outstanding", found, 1'b1);
    chk1("t3_req_blocked", imem_req_o, 1'b0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    cyc();
    redirect_i = 1'b0;
    chk("t3_addr", imem_addr_o, 32'h0000_0100);
    chk1("t3_flushed", instr_valid_o, 1'b0);
    chk1("t3_req_wait_discard", imem_req_o, 1'b0);
    rsp_en = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid_o) found = 1'b1;
      else cyc();
    end
    chk1("t3_valid_seen", found, 1'b1);
    chk("t3_pc", instr_pc_o, 32'h0000_0100);
    chk("t3_data", instr_o, 32'h1257_6520);

    // Redirect to a misaligned target in a cycle with both grant and response.
    repeat (3) cyc();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_req() && imem_gnt_i && imem_rvalid_i) found = 1'b1;
      else cyc();
    end
    chk1("t4_gnt_rvalid_cycle", found, 1'b1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0203;
    cyc();
    redirect_i = 1'b0;
    chk("t4_addr", imem_addr_o, 32'h0000_0200);
    chk1("t4_flushed", instr_valid_o, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid_o) found = 1'b1;
      else cyc();
    end
    chk1("t4_valid_seen", found, 1'b1);
    chk("t4_pc", instr_pc_o, 32'h0000_0200);
    chk("t4_data", instr_o, 32'h1157_6620);

    // Grant withheld: address and request must hold.
    imem_gnt_i = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_req()) found = 1'b1;
      else cyc();
    end
    chk1("t5_req_ready", found, 1'b1);
    a = imem_addr_o;
    for (int i = 0; i < 5; i++) begin
      chk("t5_addr_hold", imem_addr_o, a);
      chk1("t5_req_hold", imem_req_o, 1'b1);
      cyc();
    end
    imem_gnt_i = 1'b1;
    cyc();
    chk("t5_addr_adv", imem_addr_o, a + 32'd4);

    // Reset in the middle of a stalled, full stream.
    instr_ready_i = 1'b0;
    repeat (8) cyc();
    chk1("t6_full_valid", instr_valid_o, 1'b1);
    rst_n         = 1'b0;
    imem_rvalid_i = 1'b0;
    cyc();
    chk1("t6_valid", instr_valid_o, 1'b0);
    chk1("t6_req", imem_req_o, 1'b0);
    chk("t6_addr", imem_addr_o, RST_PC);
    chk("t6_instr", instr_o, 32'h0);
    chk("t6_instr_pc", instr_pc_o, 32'h0);
    rst_n         = 1'b1;
    instr_ready_i = 1'b1;
    #1;
    chk1("t6_req_restart", imem_req_o, 1'b1);
    repeat (12) cyc();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
